// File: rtl/hsv_pkg.sv
// Shared constants and types for the HSV hue sequencing controller.
// Contents: channel index encoding, controller FSM state enum, and the
// 60-degree sector multipliers used to place hue within the colour wheel.
package hsv_pkg;

  // Channel indices reported on max_index / min_index.
  localparam logic [1:0] CH_RED   = 2'd0;
  localparam logic [1:0] CH_GREEN = 2'd1;
  localparam logic [1:0] CH_BLUE  = 2'd2;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Sector base in units of one 60-degree sector (scaled by 2^FRAC_BITS).
  localparam int unsigned SEC_RED   = 0;
  localparam int unsigned SEC_GREEN = 2;
  localparam int unsigned SEC_BLUE  = 4;
  localparam int unsigned SEC_COUNT = 6;

endpackage

// File: rtl/serial_div.sv
// Serial restoring divider, one quotient bit per enabled clock.
// Ports:
//   clk, rst (async, active-high), ce (clock enable)
//   start      : load dividend/divisor and begin (ignored while ce=0)
//   dividend   : DVD_W-bit unsigned numerator
//   divisor    : DVS_W-bit unsigned denominator (must be non-zero)
//   busy       : registered, high while quotient bits are being produced
//   done_c     : combinational, high in the cycle whose edge retires the last bit
//   quotient_c : combinational quotient as it will stand after that edge,
//                optionally rounded to nearest (ROUND_NEAREST)
module serial_div #(
  parameter int unsigned DVD_W         = 18,
  parameter int unsigned DVS_W         = 10,
  parameter bit          ROUND_NEAREST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done_c,
  output logic [DVD_W-1:0] quotient_c
);

  localparam int unsigned CNT_W = $clog2(DVD_W + 1);

  logic [CNT_W-1:0] cnt;
  logic [DVS_W-1:0] dvs;
  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] rem_nxt;
  logic [DVD_W-1:0] quo;
  logic [DVD_W-1:0] quo_nxt;
  logic [DVS_W:0]   trial;
  logic             ge;
  logic             round_up;

  // One restoring step; quo shifts dividend bits out and quotient bits in.
  always_comb begin
    trial      = {rem, quo[DVD_W-1]};
    ge         = (trial >= {1'b0, dvs});
    rem_nxt    = ge ? DVS_W'(trial - {1'b0, dvs}) : DVS_W'(trial);
    quo_nxt    = {quo[DVD_W-2:0], ge};
    round_up   = ROUND_NEAREST && ({rem_nxt, 1'b0} >= {1'b0, dvs});
    quotient_c = quo_nxt + DVD_W'(round_up);
    done_c     = busy && (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      dvs  <= '0;
      rem  <= '0;
      quo  <= '0;
      busy <= 1'b0;
    end else if (ce) begin
      if (start) begin
        dvs  <= divisor;
        quo  <= dividend;
        rem  <= '0;
        cnt  <= CNT_W'(DVD_W);
        busy <= 1'b1;
      end else if (busy) begin
        quo <= quo_nxt;
        rem <= rem_nxt;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hue_seq_ctrl.sv
// HSV hue sequencing controller for the skin-detection colour-space stage.
// Accepts one RGB pixel per transaction, finds max/min channels, divides the
// sector difference by delta with a shared serial divider and emits hue,
// value and delta over a valid/ready handshake.
// Build option: define HUE_ROUND_EN to round the sector fraction to nearest
// instead of truncating (latency unchanged).
// Ports:
//   clk, rst (async, active-high), ce (clock enable, low freezes everything)
//   in_valid/in_ready, red/green/blue      : pixel input handshake
//   out_valid/out_ready, hue/value/delta,
//   max_index/min_index                    : result output handshake
module hue_seq_ctrl
  import hsv_pkg::*;
#(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned HUE_W     = FRAC_BITS + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] red,
  input  logic [DATA_W-1:0] green,
  input  logic [DATA_W-1:0] blue,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HUE_W-1:0]  hue,
  output logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] delta,
  output logic [1:0]        max_index,
  output logic [1:0]        min_index
);

  localparam int unsigned DIFF_W = DATA_W + 1;
  localparam int unsigned DVD_W  = DATA_W + FRAC_BITS;
  localparam int unsigned SUM_W  = DVD_W + 2;
`ifdef HUE_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  state_t            state;
  logic              in_ready_q;
  logic              neg_q;
  logic [DATA_W-1:0] r_q, g_q, b_q;

  logic [1:0]               max_idx_c, min_idx_c;
  logic [DATA_W-1:0]        max_val_c, min_val_c, delta_c;
  logic signed [DIFF_W-1:0] diff_c;
  logic [DIFF_W-1:0]        abs_c;
  logic [DVD_W-1:0]         dividend_c;
  logic                     div_start_c;
  logic                     div_busy;
  logic                     div_done_c;
  logic [DVD_W-1:0]         div_quot_c;
  logic [SUM_W-1:0]         base_c;
  logic signed [SUM_W-1:0]  mag_c, sum_c;
  logic [HUE_W-1:0]         hue_div_c;

  // ce low masks the registered ready so no pixel is taken while frozen.
  assign in_ready = in_ready_q && ce;

  // Max/min selection (ties favour red, then green) and the sector difference.
  always_comb begin
    max_idx_c = CH_RED;
    max_val_c = r_q;
    if (!(r_q >= g_q && r_q >= b_q)) begin
      if (g_q >= b_q) begin
        max_idx_c = CH_GREEN;
        max_val_c = g_q;
      end else begin
        max_idx_c = CH_BLUE;
        max_val_c = b_q;
      end
    end
    min_idx_c = CH_RED;
    min_val_c = r_q;
    if (!(r_q <= g_q && r_q <= b_q)) begin
      if (g_q <= b_q) begin
        min_idx_c = CH_GREEN;
        min_val_c = g_q;
      end else begin
        min_idx_c = CH_BLUE;
        min_val_c = b_q;
      end
    end
    delta_c = max_val_c - min_val_c;
    case (max_idx_c)
      CH_RED:   diff_c = $signed({1'b0, g_q}) - $signed({1'b0, b_q});
      CH_GREEN: diff_c = $signed({1'b0, b_q}) - $signed({1'b0, r_q});
      default:  diff_c = $signed({1'b0, r_q}) - $signed({1'b0, g_q});
    endcase
    abs_c       = diff_c[DIFF_W-1] ? DIFF_W'(-diff_c) : DIFF_W'(diff_c);
    dividend_c  = DVD_W'({abs_c, {FRAC_BITS{1'b0}}});
    div_start_c = ce && (state == S_CMP) && (delta_c != '0);
  end

  // Final hue from the divider's last-step quotient, wrapped into 0..6 sectors.
  always_comb begin
    case (max_index)
      CH_RED:   base_c = SUM_W'(SEC_RED) << FRAC_BITS;
      CH_GREEN: base_c = SUM_W'(SEC_GREEN) << FRAC_BITS;
      default:  base_c = SUM_W'(SEC_BLUE) << FRAC_BITS;
    endcase
    mag_c = $signed(SUM_W'(div_quot_c));
    sum_c = $signed(base_c) + (neg_q ? -mag_c : mag_c);
    if (sum_c[SUM_W-1]) begin
      sum_c = sum_c + $signed(SUM_W'(SEC_COUNT) << FRAC_BITS);
    end
    hue_div_c = HUE_W'(sum_c);
  end

  serial_div #(
    .DVD_W        (DVD_W),
    .DVS_W        (DATA_W),
    .ROUND_NEAREST(ROUND)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .start     (div_start_c),
    .dividend  (dividend_c),
    .divisor   (delta_c),
    .busy      (div_busy),
    .done_c    (div_done_c),
    .quotient_c(div_quot_c)
  );

  // Sequencer: single outstanding transaction, outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready_q <= 1'b0;
      neg_q      <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      out_valid  <= 1'b0;
      hue        <= '0;
      value      <= '0;
      delta      <= '0;
      max_index  <= '0;
      min_index  <= '0;
    end else if (ce) begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            r_q        <= red;
            g_q        <= green;
            b_q        <= blue;
            in_ready_q <= 1'b0;
            state      <= S_CMP;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_CMP: begin
          value     <= max_val_c;
          delta     <= delta_c;
          max_index <= max_idx_c;
          min_index <= min_idx_c;
          neg_q     <= diff_c[DIFF_W-1];
          if (delta_c == '0) begin
            hue       <= '0;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            state <= S_DIV;
          end
        end
        S_DIV: begin
          if (div_busy && div_done_c) begin
            hue       <= hue_div_c;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            in_ready_q <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hue_seq_ctrl.sv
// Directed scoreboard bench for hue_seq_ctrl.
module tb_hue_seq_ctrl;

  localparam int F  = 8;
  localparam int DW = 10;

  typedef struct {
    int hue;
    int value;
    int delta;
    int maxi;
    int mini;
    int lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [9:0]  red = '0, green = '0, blue = '0;
  logic        in_ready, out_valid;
  logic [10:0] hue;
  logic [9:0]  value, delta;
  logic [1:0]  max_index, min_index;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   acc_cyc = 0;
  exp_t sb[$];

  hue_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .hue      (hue),
    .value    (value),
    .delta    (delta),
    .max_index(max_index),
    .min_index(min_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input int r, input int g, input int b);
    exp_t e;
    int mx, mn, d, diff, ad, q, rm, h;
    if (r >= g && r >= b) begin e.maxi = 0; mx = r; end
    else if (g >= b)      begin e.maxi = 1; mx = g; end
    else                  begin e.maxi = 2; mx = b; end
    if (r <= g && r <= b) begin e.mini = 0; mn = r; end
    else if (g <= b)      begin e.mini = 1; mn = g; end
    else                  begin e.mini = 2; mn = b; end
    d = mx - mn;
    e.value = mx;
    e.delta = d;
    if (e.maxi == 0)      diff = g - b;
    else if (e.maxi == 1) diff = b - r;
    else                  diff = r - g;
    if (d == 0) begin
      e.hue = 0;
      e.lat = 2;
    end else begin
      ad = (diff < 0) ? -diff : diff;
      q  = (ad * (1 << F)) / d;
      rm = (ad * (1 << F)) % d;
`ifdef HUE_ROUND_EN
      if (2 * rm >= d) q = q + 1;
`else
      if (rm < 0) q = q - 1;
`endif
      h = e.maxi * 2 * (1 << F) + ((diff < 0) ? -q : q);
      if (h < 0) h = h + 6 * (1 << F);
      e.hue = h;
      e.lat = 2 + DW + F;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input int r, input int g, input int b);
    int n;
    n = 0;
    red      = 10'(r);
    green    = 10'(g);
    blue     = 10'(b);
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (n == 60) check("in_ready_timeout", 32'(in_ready), 1);
    tick();
    acc_cyc = cyc;
    sb.push_back(model(r, g, b));
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int hold, input int extra);
    exp_t e;
    int   n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) begin
      check("out_valid_timeout", 32'(out_valid), 1);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat + extra));
    check("hue", 32'(hue), 32'(e.hue));
    check("value", 32'(value), 32'(e.value));
    check("delta", 32'(delta), 32'(e.delta));
    check("max_index", 32'(max_index), 32'(e.maxi));
    check("min_index", 32'(min_index), 32'(e.mini));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_out_valid", 32'(out_valid), 1);
      check("hold_hue", 32'(hue), 32'(e.hue));
      check("hold_value", 32'(value), 32'(e.value));
      check("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    check("out_valid_drop", 32'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset values
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_hue", 32'(hue), 0);
    tick();
    tick();
    rst = 1'b0;
    check("in_ready_after_release", 32'(in_ready), 0);
    tick();
    check("in_ready_first_edge", 32'(in_ready), 1);

    // Directed colours
    send_pixel(1023, 0, 0);       wait_out(0, 0);
    send_pixel(1023, 1023, 0);    wait_out(0, 0);
    send_pixel(0, 1023, 0);       wait_out(0, 0);
    send_pixel(1023, 0, 1023);    wait_out(0, 0);
    send_pixel(512, 512, 512);    wait_out(0, 0);
    send_pixel(600, 301, 100);    wait_out(0, 0);
    send_pixel(0, 0, 1023);       wait_out(0, 0);
    send_pixel(100, 700, 900);    wait_out(0, 0);
    for (int i = 0; i < 4; i++) begin
      send_pixel(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 1023)));
      wait_out(0, 0);
    end

    // ce low in IDLE forces in_ready low
    ce = 1'b0;
    #1;
    check("ce_low_in_ready", 32'(in_ready), 0);
    tick();
    tick();
    check("ce_low_in_ready_hold", 32'(in_ready), 0);
    ce = 1'b1;
    #1;
    check("ce_high_in_ready", 32'(in_ready), 1);

    // Back-pressure with a second pixel waiting
    send_pixel(200, 50, 400);
    red = 10'd300; green = 10'd900; blue = 10'd10;
    in_valid = 1'b1;
    wait_out(5, 0);
    check("idle_in_ready", 32'(in_ready), 1);
    send_pixel(300, 900, 10);
    wait_out(0, 0);

    // ce low for 3 cycles during the division
    send_pixel(700, 100, 350);
    for (int i = 0; i < 5; i++) tick();
    check("div_out_valid", 32'(out_valid), 0);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    ce = 1'b1;
    wait_out(0, 3);

    // Reset in the middle of a division
    send_pixel(600, 301, 100);
    for (int i = 0; i < 8; i++) tick();
    check("mid_div_value", 32'(value), 600);
    check("mid_div_out_valid", 32'(out_valid), 0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_value", 32'(value), 0);
    check("mid_rst_delta", 32'(delta), 0);
    check("mid_rst_max_index", 32'(max_index), 0);
    check("mid_rst_min_index", 32'(min_index), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    void'(sb.pop_front());
    tick();
    rst = 1'b0;
    send_pixel(50, 800, 200);
    wait_out(0, 0);
    send_pixel(1, 1, 1);
    wait_out(0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
